// File: rtl/route_hop_reader.sv
// ----------------------------------------------------------------------------
// route_hop_reader
//
// Consumer end of the router's hop-stack interface. The routing engine pushes
// one {pe, dir} hop record per routing step and then either commits the
// finished edge or aborts it. On commit the stored hops are replayed in push
// order over a valid/ready stream. Each replayed hop is annotated with the
// neighbour PE in its direction, a last-hop flag and a grid-boundary error.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_valid/wr_ready     hop push handshake; wr_pe, wr_dir carry the hop
//   commit, abort         single-cycle edge-complete / discard pulses
//   hop_valid/hop_ready   replay stream handshake
//   hop_pe, hop_dir       replayed hop record
//   hop_next_pe           neighbour PE in hop_dir (equals hop_pe on error)
//   hop_last              final hop of the edge
//   hop_err               hop_dir leaves the grid, or hop_pe is off-grid
//   edge_count            edges fully drained (wraps 255 -> 0)
//   overflow              sticky: a push was dropped because the store was full
// ----------------------------------------------------------------------------
module route_hop_reader #(
    parameter int DEPTH  = 8,
    parameter int GRID_W = 4,
    parameter int GRID_H = 4,
    parameter int PE_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [PE_W-1:0] wr_pe,
    input  logic [1:0]      wr_dir,
    input  logic            commit,
    input  logic            abort,
    output logic            hop_valid,
    input  logic            hop_ready,
    output logic [PE_W-1:0] hop_pe,
    output logic [1:0]      hop_dir,
    output logic [PE_W-1:0] hop_next_pe,
    output logic            hop_last,
    output logic            hop_err,
    output logic [7:0]      edge_count,
    output logic            overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    localparam logic [1:0] DIR_BOT   = 2'd0;
    localparam logic [1:0] DIR_TOP   = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;     // also serves as the write pointer
    logic [PTR_W-1:0] r_rd_ptr;
    logic [7:0]       r_edge_count;
    logic             r_overflow;

    logic [PE_W-1:0]  r_mem_pe  [DEPTH];
    logic [1:0]       r_mem_dir [DEPTH];

    logic w_fill;
    logic w_push;
    int   w_pe_i;
    int   w_col;
    int   w_row;
    int   w_next_i;
    logic w_err;

    assign w_fill   = (r_state == S_FILL);
    assign wr_ready = w_fill && (r_count < DEPTH_C);
    assign w_push   = wr_valid && wr_ready;

    assign hop_valid  = (r_state == S_DRAIN);
    assign hop_pe     = r_mem_pe[r_rd_ptr];
    assign hop_dir    = r_mem_dir[r_rd_ptr];
    assign hop_last   = ({1'b0, r_rd_ptr} == (r_count - CNT_W'(1)));
    assign edge_count = r_edge_count;
    assign overflow   = r_overflow;

    // Neighbour lookup on the PE currently at the head of the replay.
    // Off-grid moves leave the PE unchanged and flag hop_err.
    always_comb begin
        w_pe_i   = int'(hop_pe);
        w_col    = w_pe_i % GRID_W;
        w_row    = w_pe_i / GRID_W;
        w_next_i = w_pe_i;
        w_err    = 1'b0;
        if (w_pe_i >= GRID_W * GRID_H) begin
            w_err = 1'b1;
        end else begin
            case (hop_dir)
                DIR_RIGHT: if (w_col == GRID_W - 1) w_err = 1'b1; else w_next_i = w_pe_i + 1;
                DIR_LEFT:  if (w_col == 0)          w_err = 1'b1; else w_next_i = w_pe_i - 1;
                DIR_TOP:   if (w_row == 0)          w_err = 1'b1; else w_next_i = w_pe_i - GRID_W;
                DIR_BOT:   if (w_row == GRID_H - 1) w_err = 1'b1; else w_next_i = w_pe_i + GRID_W;
                default:   w_err = 1'b1;
            endcase
        end
    end

    assign hop_next_pe = PE_W'(w_next_i);
    assign hop_err     = w_err;

    // NOTE: the hop store carries no reset; count/pointers define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push && !abort) begin
            r_mem_pe[r_count[PTR_W-1:0]]  <= wr_pe;
            r_mem_dir[r_count[PTR_W-1:0]] <= wr_dir;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every branch
    // sees the pre-edge values of r_count/r_rd_ptr regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_edge_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (wr_valid && !wr_ready) r_overflow <= 1'b1;
                    // Abort wins over a same-cycle commit and swallows any push.
                    if (abort) begin
                        r_count <= '0;
                    end else begin
                        if (w_push) r_count <= r_count + CNT_W'(1);
                        // A push accepted in the commit cycle belongs to the edge.
                        if (commit && ((r_count != '0) || w_push)) begin
                            r_state  <= S_DRAIN;
                            r_rd_ptr <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (hop_ready) begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                        if (hop_last) begin
                            r_state      <= S_FILL;
                            r_count      <= '0;
                            r_edge_count <= r_edge_count + 8'd1;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_route_hop_reader.sv
// ----------------------------------------------------------------------------
// tb_route_hop_reader
//
// Self-checking bench for route_hop_reader. A transaction-level reference
// model (a hop list, a replay index and a few counters) is advanced once per
// clock from the same inputs the DUT sees; every cycle the DUT outputs are
// compared against it. Directed scenarios cover the test plan, followed by a
// randomized phase.
// ----------------------------------------------------------------------------
module tb_route_hop_reader;

    localparam int DEPTH  = 8;
    localparam int GRID_W = 4;
    localparam int GRID_H = 4;
    localparam int PE_W   = 4;

    logic            clk;
    logic            reset;
    logic            wr_valid;
    logic            wr_ready;
    logic [PE_W-1:0] wr_pe;
    logic [1:0]      wr_dir;
    logic            commit;
    logic            abort;
    logic            hop_valid;
    logic            hop_ready;
    logic [PE_W-1:0] hop_pe;
    logic [1:0]      hop_dir;
    logic [PE_W-1:0] hop_next_pe;
    logic            hop_last;
    logic            hop_err;
    logic [7:0]      edge_count;
    logic            overflow;

    route_hop_reader #(
        .DEPTH (DEPTH),
        .GRID_W(GRID_W),
        .GRID_H(GRID_H),
        .PE_W  (PE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_pe      (wr_pe),
        .wr_dir     (wr_dir),
        .commit     (commit),
        .abort      (abort),
        .hop_valid  (hop_valid),
        .hop_ready  (hop_ready),
        .hop_pe     (hop_pe),
        .hop_dir    (hop_dir),
        .hop_next_pe(hop_next_pe),
        .hop_last   (hop_last),
        .hop_err    (hop_err),
        .edge_count (edge_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int pe;
        int dir;
    } hop_t;

    hop_t m_store[DEPTH];
    int   m_n     = 0;   // hops held for the current edge
    int   m_rd    = 0;   // index of hop being replayed
    bit   m_drain = 0;   // edge committed and being replayed
    int   m_edges = 0;
    bit   m_ovf   = 0;

    function automatic void neighbour(input int pe, input int dir, output int nxt, output bit err);
        int col = pe % GRID_W;
        int row = pe / GRID_W;
        nxt = pe;
        err = 0;
        if (pe >= GRID_W * GRID_H) err = 1;
        else if (dir == 3) begin if (col == GRID_W - 1) err = 1; else nxt = pe + 1; end
        else if (dir == 2) begin if (col == 0) err = 1; else nxt = pe - 1; end
        else if (dir == 1) begin if (row == 0) err = 1; else nxt = pe - GRID_W; end
        else begin if (row == GRID_H - 1) err = 1; else nxt = pe + GRID_W; end
    endfunction

    task automatic check_outputs();
        int nxt;
        bit err;
        check("hop_valid", hop_valid, m_drain);
        check("wr_ready", wr_ready, (!m_drain && m_n < DEPTH));
        check("edge_count", edge_count, m_edges);
        check("overflow", overflow, m_ovf);
        if (m_drain) begin
            neighbour(m_store[m_rd].pe, m_store[m_rd].dir, nxt, err);
            check("hop_pe", hop_pe, m_store[m_rd].pe);
            check("hop_dir", hop_dir, m_store[m_rd].dir);
            check("hop_next_pe", hop_next_pe, nxt);
            check("hop_last", hop_last, (m_rd == m_n - 1));
            check("hop_err", hop_err, err);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_drain = 0; m_n = 0; m_rd = 0; m_edges = 0; m_ovf = 0;
        end else if (!m_drain) begin
            if (wr_valid && m_n == DEPTH) m_ovf = 1;
            if (abort) m_n = 0;
            else begin
                if (wr_valid && m_n < DEPTH) begin
                    m_store[m_n] = '{int'(wr_pe), int'(wr_dir)};
                    m_n++;
                end
                if (commit && m_n > 0) begin
                    m_drain = 1;
                    m_rd    = 0;
                end
            end
        end else if (hop_ready) begin
            m_rd++;
            if (m_rd == m_n) begin
                m_drain = 0;
                m_n     = 0;
                m_edges = (m_edges + 1) % 256;
            end
        end
    endtask

    // One clock: check outputs mid-cycle, let the edge happen, advance model,
    // then return the pulse inputs to idle.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
        wr_valid = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic push(input int pe, input int dir);
        wr_valid = 1'b1;
        wr_pe    = PE_W'(pe);
        wr_dir   = 2'(dir);
        cycle();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cycle();
    endtask

    task automatic drain();
        hop_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && m_drain; i++) cycle();
        check("drain_done", hop_valid, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        check("rst_hop_valid", hop_valid, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_edge_count", edge_count, 0);
        check("rst_overflow", overflow, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_pe     = '0;
        wr_dir    = '0;
        commit    = 1'b0;
        abort     = 1'b0;
        hop_ready = 1'b1;
        @(posedge clk);
        #1;

        // 1. basic route
        do_reset();
        push(5, 3);
        push(6, 0);
        do_commit();
        drain();
        check("t1_edges", edge_count, 1);
        check("t1_wr_ready", wr_ready, 1'b1);

        // 2. backpressure on hop 1
        push(5, 3);
        push(6, 0);
        do_commit();
        hop_ready = 1'b0;
        repeat (3) cycle();
        check("t2_hold_pe", hop_pe, 5);
        check("t2_hold_valid", hop_valid, 1'b1);
        drain();
        check("t2_edges", edge_count, 2);

        // 3. overflow
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(i, 0);
            if (i == 7) check("t3_full_ready", wr_ready, 1'b0);
        end
        check("t3_overflow", overflow, 1'b1);
        do_commit();
        drain();
        check("t3_edges", edge_count, 1);
        check("t3_ovf_sticky", overflow, 1'b1);

        // 4. abort beats commit, then empty commit
        do_reset();
        push(1, 3);
        push(2, 3);
        push(3, 0);
        abort  = 1'b1;
        commit = 1'b1;
        cycle();
        check("t4_abort_valid", hop_valid, 1'b0);
        do_commit();
        check("t4_empty_valid", hop_valid, 1'b0);
        check("t4_edges", edge_count, 0);
        cycle();

        // 5. boundary errors
        push(3, 3);
        push(0, 2);
        push(1, 1);
        push(14, 0);
        do_commit();
        drain();
        push(5, 1);
        do_commit();
        check("t5_top_next", hop_next_pe, 1);
        check("t5_top_err", hop_err, 1'b0);
        drain();

        // 6. reset mid-drain
        push(1, 3);
        push(2, 3);
        push(3, 0);
        push(7, 0);
        do_commit();
        hop_ready = 1'b1;
        cycle();
        do_reset();
        push(9, 3);
        do_commit();
        check("t6_last", hop_last, 1'b1);
        check("t6_next", hop_next_pe, 10);
        drain();

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            wr_valid  = ($urandom_range(0, 9) < 6);
            wr_pe     = PE_W'($urandom_range(0, 15));
            wr_dir    = 2'($urandom_range(0, 3));
            commit    = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 31) == 0);
            hop_ready = ($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/route_hop_reader.md
Name: route_hop_reader

Overview:
- Consumer end of the router's hop-stack interface.
- The routing engine pushes one hop record (PE index plus outgoing direction) per routing step. It then commits the finished edge, or aborts it on blacklist/rollback.
- On commit, this block replays the stored hops in push order (source to destination) over a valid/ready stream. Each replayed hop is annotated with the neighbour PE, a last-hop flag and a grid-boundary error.
- It feeds the downstream configuration emitter and checker.

Parameters:
- DEPTH, 8, hop-store entries (maximum hops per edge).
- GRID_W, 4, CGRA columns.
- GRID_H, 4, CGRA rows.
- PE_W, 4, PE index width (GRID_W*GRID_H <= 2**PE_W).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- wr_valid  input  1  hop push request
- wr_ready  output  1  block can accept a push
- wr_pe  input  PE_W  PE index of hop
- wr_dir  input  2  direction: 3=right, 2=left, 1=top, 0=bot
- commit  input  1  single-cycle pulse: current edge complete
- abort  input  1  single-cycle pulse: discard stored hops
- hop_valid  output  1  hop record available
- hop_ready  input  1  downstream accepts hop
- hop_pe  output  PE_W  PE index
- hop_dir  output  2  direction
- hop_next_pe  output  PE_W  neighbour PE in hop_dir
- hop_last  output  1  final hop of edge
- hop_err  output  1  hop_dir leaves grid from hop_pe
- edge_count  output  8  edges fully drained, wraps 255->0
- overflow  output  1  sticky: push dropped because store full

Behaviour:
- Reset is synchronous and active-high on clk. It is honoured in any state, including mid-drain.
  - State goes to FILL.
  - wr_ptr, rd_ptr and count are cleared.
  - edge_count=0, overflow=0, hop_valid=0.
  - Store contents need not be cleared.
- Store: DEPTH entries of {pe, dir}. count is log2(DEPTH)+1 bits.
- wr_ready = (state==FILL) && (count<DEPTH). It is combinational from registers, so it reads 1 immediately after reset.
- FILL state:
  - Push: wr_valid && wr_ready writes entry[count] and increments count.
  - Full: wr_valid with count==DEPTH is not written and sets overflow. overflow stays set until reset.
  - Abort: count<=0. Abort beats a same-cycle commit, and a same-cycle push is also discarded.
  - Commit with count==0 (no push in the same cycle): ignored, state stays FILL, edge_count unchanged.
  - Commit with count>0, or with a same-cycle accepted push: the push is included in the edge. rd_ptr<=0 and the next state is DRAIN.
- DRAIN state:
  - hop_valid=1. hop_pe and hop_dir come from entry[rd_ptr].
  - hop_last = (rd_ptr==count-1).
  - Handshake: hop_valid && hop_ready advances rd_ptr. Outputs must hold stable while hop_ready=0.
  - Handshake on the last hop: state goes to FILL, count<=0, edge_count increments.
  - wr_valid is ignored (wr_ready=0) and not written.
  - commit and abort are ignored.
- Latency: the first hop_valid is asserted the cycle after the commit is sampled. Throughput is one hop per cycle with hop_ready held high.
- Neighbour arithmetic: col = pe % GRID_W, row = pe / GRID_W.
  - right: pe+1, error if col==GRID_W-1.
  - left: pe-1, error if col==0.
  - top: pe-GRID_W, error if row==0.
  - bot: pe+GRID_W, error if row==GRID_H-1.
  - On error, hop_next_pe = hop_pe and hop_err=1. hop_err is informational and does not stall the stream.
  - hop_pe >= GRID_W*GRID_H also forces hop_err=1.
- hop_* outputs other than hop_valid are don't-care in FILL. The bench checks them only when hop_valid=1.

Test Plan:
1. Basic route (4x4 grid): push (5,right), (6,bot), then commit.
   - Hop 1: pe=5, dir=3, next=6, last=0, err=0.
   - Hop 2: pe=6, dir=0, next=10, last=1, err=0.
   - edge_count=1; wr_ready returns to 1 after the last handshake.
2. Backpressure: same route with hop_ready low for 3 cycles on hop 1.
   - hop_valid=1 and pe=5 hold stable throughout.
   - Hop 2 appears only after hop_ready rises.
   - Exactly 2 handshakes occur.
3. Overflow: push 9 hops (pe 0..8, dir=bot), then commit.
   - wr_ready=0 after the 8th push; overflow=1.
   - 8 hops are drained with hop_last on pe=7.
   - hop_err=1 on pe 12..15 only if pushed (none here).
4. Abort and empty commit:
   - Push 3 hops, then abort with commit in the same cycle: no hop_valid, count=0.
   - A subsequent commit with no pushes: no hop_valid, edge_count unchanged.
5. Boundary errors: push (3,right), (0,left), (1,top), (14,bot), then commit.
   - All four hops report err=1 with next_pe equal to pe.
   - (5,top) in a separate edge reports next=1, err=0.
6. Reset mid-drain: push 4 hops, commit, accept 1 hop, then assert reset for 1 cycle.
   - Next cycle: hop_valid=0, wr_ready=1, edge_count=0, overflow=0.
   - A new 1-hop edge drains correctly with last=1.
